// File: rtl/lcd_hex_writer.sv
// lcd_hex_writer: turns a latched binary value into ASCII hex characters and
// writes them, one strobe per character, into the LCD character buffer via
// the LcdController writeEnable/location/data interface.
//
// Optional build macro: LCD_HEX_WRITER_BLANK_EN
//   defined   -> leading zero nibbles are written as spaces (8'h20); the least
//                significant digit is always printed. Strobe count and timing
//                are unchanged.
//   undefined -> every digit is printed literally ("0000").
module lcd_hex_writer #(
  parameter int DIGITS    = 4,
  parameter int WRITE_GAP = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [4:0]            baseLocation,
  output logic                  busy,
  output logic                  done,
  output logic                  writeEnable,
  output logic [4:0]            location,
  output logic [7:0]            data
);

  localparam int VW = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int GW = (WRITE_GAP > 1) ? $clog2(WRITE_GAP) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
  localparam logic [GW-1:0] LAST_GAP = GW'((WRITE_GAP > 0) ? WRITE_GAP - 1 : 0);
  localparam bit            HAS_GAP  = (WRITE_GAP > 0);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_GAP, S_DONE} state_t;

  state_t          r_state;
  logic [IW-1:0]   r_idx;
  logic [GW-1:0]   r_gap;
  // Remaining digits, most significant nibble at the top; shifted left by one
  // nibble each time a digit is consumed so the next digit is always on top.
  logic [VW-1:0]   r_shift;
  logic            r_busy;
  logic            r_done;
  logic            r_we;
  logic [4:0]      r_loc;
  logic [7:0]      r_data;

  logic [3:0]      w_first_nib;
  logic [3:0]      w_next_nib;
  logic [IW-1:0]   w_next_idx;
  logic            w_idx_last;
  logic            w_adv;
  logic [7:0]      w_first_char;
  logic [7:0]      w_next_char;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign w_first_nib = value[VW-1 -: 4];
  assign w_next_nib  = r_shift[VW-1 -: 4];
  assign w_next_idx  = r_idx + IW'(1);
  assign w_idx_last  = (r_idx == LAST_IDX);

  // Move on to the next digit (or finish) after a strobe with no gap, or at
  // the end of the last gap cycle.
  assign w_adv = ((r_state == S_WRITE) && !HAS_GAP) ||
                 ((r_state == S_GAP) && (r_gap == LAST_GAP));

`ifdef LCD_HEX_WRITER_BLANK_EN
  // r_lead stays set while every digit written so far has been zero.
  logic r_lead;
  logic w_next_last;
  assign w_next_last  = (w_next_idx == LAST_IDX);
  assign w_first_char = ((w_first_nib == 4'h0) && (DIGITS > 1)) ? 8'h20
                                                               : hex_ascii(w_first_nib);
  assign w_next_char  = (r_lead && (w_next_nib == 4'h0) && !w_next_last) ? 8'h20
                                                                        : hex_ascii(w_next_nib);
`else
  assign w_first_char = hex_ascii(w_first_nib);
  assign w_next_char  = hex_ascii(w_next_nib);
`endif

  // Sequencer: accepts a start, strobes each digit, paces with gap cycles and
  // pulses done; all outputs are registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_gap   <= '0;
      r_shift <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_we    <= 1'b0;
      r_loc   <= '0;
      r_data  <= '0;
`ifdef LCD_HEX_WRITER_BLANK_EN
      r_lead  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        // DONE behaves like IDLE for acceptance, so a start in the done cycle
        // launches the next sequence without a bubble.
        S_IDLE, S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_we    <= 1'b0;
          if (start) begin
            r_state <= S_WRITE;
            r_busy  <= 1'b1;
            r_we    <= 1'b1;
            r_idx   <= '0;
            r_gap   <= '0;
            r_shift <= value << 4;
            r_loc   <= baseLocation;
            r_data  <= w_first_char;
`ifdef LCD_HEX_WRITER_BLANK_EN
            r_lead  <= (w_first_nib == 4'h0);
`endif
          end
        end
        S_WRITE: begin
          if (HAS_GAP) begin
            r_state <= S_GAP;
            r_we    <= 1'b0;
            r_gap   <= '0;
          end
        end
        S_GAP: begin
          if (!w_adv) r_gap <= r_gap + GW'(1);
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_adv) begin
        r_gap <= '0;
        if (w_idx_last) begin
          r_state <= S_DONE;
          r_we    <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end else begin
          r_state <= S_WRITE;
          r_we    <= 1'b1;
          r_idx   <= w_next_idx;
          r_loc   <= r_loc + 5'd1;
          r_data  <= w_next_char;
          r_shift <= r_shift << 4;
`ifdef LCD_HEX_WRITER_BLANK_EN
          r_lead  <= r_lead && (w_next_nib == 4'h0);
`endif
        end
      end
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign writeEnable = r_we;
  assign location    = r_loc;
  assign data        = r_data;

endmodule

// File: doc/lcd_hex_writer.md
Name: lcd_hex_writer

Overview:
- Upstream feeder for LcdController: converts a binary value into ASCII hex characters and writes them, one character per write strobe, into the LCD character buffer through LcdController's writeEnable/location/data interface.
- Lets the datapath display registers (PC, accumulator, bus values) by issuing one start pulse.
- Paces its writes with a configurable gap and reports busy/done to the requesting logic.

Parameters:
- DIGITS, 4, number of hex characters written; value width is 4*DIGITS.
- WRITE_GAP, 2, idle cycles inserted after each write strobe (0 = back-to-back strobes).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request to display value; sampled only when busy=0
- value  input  4*DIGITS  binary value to display; latched on accepted start
- baseLocation  input  5  LCD buffer location of the most significant character (0-15 line 1, 16-31 line 2)
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse when the final character has been written and its gap has elapsed
- writeEnable  output  1  write strobe to LcdController, one cycle per character
- location  output  5  character location, valid while writeEnable=1
- data  output  8  ASCII character, valid while writeEnable=1

Behaviour:
- Reset (asynchronous): state IDLE; busy, done and writeEnable = 0; location = 0; data = 0; digit index, gap counter and latched value cleared. Reset mid-sequence aborts it; no further strobes; no done.
- States: IDLE, WRITE, GAP, DONE.
- IDLE: on a rising edge with start=1:
  - latch value and baseLocation; digit index = 0; go to WRITE.
  - Registered outputs after that edge: busy=1, writeEnable=1, location=baseLocation, data=ASCII of the most significant nibble.
- WRITE: lasts exactly one cycle, writeEnable=1.
  - Next state is GAP if WRITE_GAP>0; otherwise the next digit's WRITE, or DONE after the last digit.
- GAP: writeEnable=0; counts WRITE_GAP cycles. Then moves to WRITE for the next digit (index+1, location+1), or to DONE after digit DIGITS-1.
- DONE: lasts one cycle with done=1, busy=0, writeEnable=0; then IDLE.
  - start is accepted in the DONE cycle, since busy=0.
- Latency: with start sampled at edge N:
  - digit k strobes in the cycle after edge N + k*(1+WRITE_GAP);
  - done is high in the cycle after edge N + DIGITS*(1+WRITE_GAP).
- Digit order: most significant nibble first, at increasing locations.
- ASCII mapping: nibble 0-9 -> 8'h30-8'h39; A-F -> 8'h41-8'h46 (upper case).
- Location arithmetic: 5-bit, modulo 32. baseLocation 30 with DIGITS=4 writes 30, 31, 0, 1. There is no line-boundary check: 14 -> 14, 15, 16, 17 continues onto line 2.
- start while busy=1 is ignored; it is not queued. Changes to value or baseLocation while busy do not affect the sequence in progress.
- location and data hold their last strobed values while writeEnable=0.

Optional Feature:
- Macro: LCD_HEX_WRITER_BLANK_EN.
- Defined:
  - Leading zero nibbles are written as space (8'h20) instead of '0'.
  - Blanking stops at the first nonzero nibble.
  - The least significant digit is always printed, so value 0 displays as "   0".
  - Strobe count and timing are unchanged: every location is still written.
- Undefined: all digits are printed literally, e.g. "0000".

Test Plan:
- Reset, then start=1 for one cycle with value=16'h1A2F, baseLocation=0, WRITE_GAP=2 -> strobes at cycle offsets 1, 4, 7, 10 with (location, data) = (0, 8'h31), (1, 8'h41), (2, 8'h32), (3, 8'h46); done high at offset 13; busy high for offsets 1-12.
- value=16'h00B0, baseLocation=30 -> locations 30, 31, 0, 1.
  - Macro undefined: data 8'h30, 8'h30, 8'h42, 8'h30.
  - Macro defined: data 8'h20, 8'h20, 8'h42, 8'h30.
- Second start pulse with value=16'hFFFF at offset 5 of a running sequence -> ignored; only the original four characters are written; exactly one done.
- Assert reset at offset 5 of a sequence -> writeEnable, busy and done go 0 immediately (asynchronous); no further strobes; a new start after reset release runs a full sequence.
- WRITE_GAP=0, value=16'h9876, baseLocation=16 -> four consecutive strobe cycles at locations 16-19 with data 8'h39, 8'h38, 8'h37, 8'h36; done in the next cycle; a start held high through the done cycle is accepted there and begins a new sequence.
